// File: rtl/flash_sample_fetcher.sv
// flash_sample_fetcher
// Reads 32-bit words from the flash controller, one Avalon-MM read at a time,
// and buffers them in a small word FIFO. Each word is unpacked into signed
// 16-bit PCM samples according to the playback rate, attenuated, and presented
// one at a time on a valid/ready stream.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   enable               allow new flash reads (an outstanding read always completes)
//   rate_sel[1:0]        00/11 normal, 01 fast (hi only), 10 slow (each sample twice)
//   flash_read           Avalon read request
//   flash_address[22:0]  Avalon word address
//   flash_waitrequest    Avalon waitrequest
//   flash_readdata[31:0] Avalon read data
//   flash_readdatavalid  Avalon read data valid
//   smp_valid            sample available
//   smp_ready            downstream accepts the sample
//   smp_data[15:0]       attenuated signed sample
//   wrap_pulse           one-cycle pulse when the word address wraps to 0

module flash_sample_fetcher #(
    parameter int unsigned WORDS      = 1048576,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SHIFT      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  rate_sel,
    output logic        flash_read,
    output logic [22:0] flash_address,
    input  logic        flash_waitrequest,
    input  logic [31:0] flash_readdata,
    input  logic        flash_readdatavalid,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [15:0] smp_data,
    output logic        wrap_pulse
);

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SMP_W  = 16;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] RATE_FAST = 2'b01;
    localparam logic [1:0] RATE_SLOW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_push;

    logic                r_flash_read;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wrap;

    logic [WORD_W-1:0]   r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_fifo_count;
    logic                w_fifo_empty;
    logic [WORD_W-1:0]   w_fifo_head;

    logic [WORD_W-1:0]   r_word;
    logic [1:0]          r_rate;
    logic [1:0]          r_phase;
    logic                r_smp_valid;
    logic [SMP_W-1:0]    r_smp_data;

    logic                w_accept;
    logic                w_last;
    logic                w_pop;
    logic [1:0]          w_phase_inc;

    // ------------------------------------------------------------------
    // Helpers for the unpacker
    // ------------------------------------------------------------------

    // Which half of the word a given phase plays at a given rate.
    function automatic logic [SMP_W-1:0] pick_sample(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        rate,
        input logic [1:0]        phase
    );
        logic use_lo;
        case (rate)
            RATE_FAST: use_lo = 1'b0;
            RATE_SLOW: use_lo = phase[1];
            default:   use_lo = phase[0];
        endcase
        return use_lo ? word[SMP_W-1:0] : word[WORD_W-1:SMP_W];
    endfunction

    // True when the given phase is the final sample of the word.
    function automatic logic is_last(
        input logic [1:0] rate,
        input logic [1:0] phase
    );
        logic last;
        case (rate)
            RATE_FAST: last = 1'b1;
            RATE_SLOW: last = (phase == 2'd3);
            default:   last = (phase == 2'd1);
        endcase
        return last;
    endfunction

    // Arithmetic attenuation, sign preserved.
    function automatic logic [SMP_W-1:0] attenuate(input logic [SMP_W-1:0] s);
        return SMP_W'($signed(s) >>> SHIFT);
    endfunction

    // ------------------------------------------------------------------
    // Read FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_flash_read <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flash_read <= (w_state_nxt == ST_REQ);
        end
    end

    // Read FSM: next state. Room is only checked in IDLE; with a single
    // outstanding read this guarantees the push always has a free slot.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && (r_fifo_count < FULL_CNT)) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!flash_waitrequest) begin
                    w_state_nxt = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word address and wrap pulse, advanced once per returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_push) begin
                if (r_addr == LAST_ADDR) begin
                    r_addr <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    assign w_fifo_empty = (r_fifo_count == '0);
    assign w_fifo_head  = r_fifo_mem[r_rd_ptr];

    // Storage needs no reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= flash_readdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Unpacker
    // ------------------------------------------------------------------
    assign w_accept    = r_smp_valid && smp_ready;
    assign w_last      = is_last(r_rate, r_phase);
    assign w_phase_inc = r_phase + 2'd1;

    // Pop either into an idle unpacker or in the same cycle the last sample
    // is taken, so consecutive words stream without a bubble.
    assign w_pop = !w_fifo_empty && (!r_smp_valid || (w_accept && w_last));

    // The rate is captured with the word so a rate change never splits it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_rate      <= 2'b00;
            r_phase     <= 2'd0;
            r_smp_valid <= 1'b0;
            r_smp_data  <= '0;
        end else begin
            if (w_pop) begin
                r_word      <= w_fifo_head;
                r_rate      <= rate_sel;
                r_phase     <= 2'd0;
                r_smp_valid <= 1'b1;
                r_smp_data  <= attenuate(w_fifo_head[WORD_W-1:SMP_W]);
            end else if (w_accept) begin
                if (w_last) begin
                    r_smp_valid <= 1'b0;
                    r_phase     <= 2'd0;
                end else begin
                    r_phase    <= w_phase_inc;
                    r_smp_data <= attenuate(pick_sample(r_word, r_rate, w_phase_inc));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign flash_read    = r_flash_read;
    assign flash_address = r_addr;
    assign wrap_pulse    = r_wrap;
    assign smp_valid     = r_smp_valid;
    assign smp_data      = r_smp_data;

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Testbench for flash_sample_fetcher: a small Avalon flash model plus a
// sample scoreboard. Directed tests push hand-computed expected samples into
// a queue; a monitor process pops and compares on every accepted sample.

module tb_flash_sample_fetcher;

    localparam int unsigned TB_WORDS = 4;
    localparam int unsigned TB_DEPTH = 4;
    localparam int unsigned TB_SHIFT = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  rate_sel;
    logic        flash_read;
    logic [22:0] flash_address;
    logic        flash_waitrequest   = 1'b0;
    logic [31:0] flash_readdata      = 32'd0;
    logic        flash_readdatavalid = 1'b0;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] smp_data;
    logic        wrap_pulse;

    flash_sample_fetcher #(
        .WORDS      (TB_WORDS),
        .FIFO_DEPTH (TB_DEPTH),
        .SHIFT      (TB_SHIFT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .rate_sel            (rate_sel),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .smp_valid           (smp_valid),
        .smp_ready           (smp_ready),
        .smp_data            (smp_data),
        .wrap_pulse          (wrap_pulse)
    );

    always #5 clk = ~clk;

    // Flash model state (written only by the model process)
    logic [31:0] mem [4];
    int          ws_cfg = 0;
    int          lat_cfg = 0;
    int          ws_cnt = 0;
    int          lat_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_data = 32'd0;
    int          rd_count = 0;
    logic [22:0] addr_log [$];
    logic        rand_mode = 1'b0;
    logic        m_acc;
    logic [22:0] m_acc_addr;

    // Scoreboard / monitor state
    logic [15:0] exp_q [$];
    int          acc_cyc [$];
    int          cyc = 0;
    int          wrap_cnt = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] hold_data = 16'd0;
    logic        wrap_prev = 1'b0;

    int checks = 0;
    int errors = 0;

    // Avalon flash model: samples the request at the edge, responds 1 ns later.
    always @(posedge clk) begin
        m_acc      = rst_n && flash_read && !flash_waitrequest;
        m_acc_addr = flash_address;
        #1;
        if (rand_mode) begin
            flash_waitrequest   = 1'($urandom);
            flash_readdatavalid = 1'($urandom);
            flash_readdata      = $urandom;
        end else begin
            flash_readdatavalid = 1'b0;
            if (m_acc) begin
                pend      = 1'b1;
                lat_cnt   = lat_cfg;
                pend_data = mem[m_acc_addr[1:0]];
                rd_count++;
                addr_log.push_back(m_acc_addr);
                ws_cnt    = 0;
            end
            if (pend) begin
                if (lat_cnt == 0) begin
                    flash_readdatavalid = 1'b1;
                    flash_readdata      = pend_data;
                    pend                = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (!rst_n) ws_cnt = 0;
            if (flash_read && ws_cnt < ws_cfg) begin
                flash_waitrequest = 1'b1;
                ws_cnt++;
            end else begin
                flash_waitrequest = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: checks every accepted sample, stream stability and wrap pulses.
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hold_prev = 1'b0;
                wrap_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid", 32'(smp_valid), 32'd1);
                    chk("hold_data", 32'(smp_data), 32'(hold_data));
                end
                if (smp_valid && smp_ready) begin
                    acc_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("sample_unexpected", 32'(smp_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sample", 32'(smp_data), 32'(e));
                    end
                end
                hold_prev = smp_valid && !smp_ready;
                hold_data = smp_data;
                if (wrap_pulse) begin
                    wrap_cnt++;
                    chk("wrap_addr", 32'(flash_address), 32'd0);
                    chk("wrap_one_cycle", 32'(wrap_prev), 32'd0);
                end
                wrap_prev = wrap_pulse;
            end
        end
    endtask

    // Raise enable until the request is seen, then drop it; n = cycles taken.
    task automatic fetch_one(output int n);
        n = 0;
        enable = 1'b1;
        while (n < 20 && !flash_read) begin
            tick();
            n++;
        end
        enable = 1'b0;
        chk("fetch_start", 32'(flash_read), 32'd1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (k < 300 && !(exp_q.size() == 0 && !smp_valid)) begin
            tick();
            k++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (k < 50 && !smp_valid) begin
            tick();
            k++;
        end
        chk("wait_valid", 32'(smp_valid), 32'd1);
    endtask

    initial begin
        int n;
        int k;
        int rd0;
        int w0;
        int lg;
        int hi;
        logic [22:0] a0;
        logic [22:0] exp_addr [5];

        rst_n     = 1'b0;
        enable    = 1'b0;
        rate_sel  = 2'b00;
        smp_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;

        fork
            monitor();
        join_none

        // ---- Reset with random inputs ----
        rand_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            enable    = 1'($urandom);
            rate_sel  = 2'($urandom);
            smp_ready = 1'($urandom);
        end
        chk("rst_flash_read", 32'(flash_read), 32'd0);
        chk("rst_flash_address", 32'(flash_address), 32'd0);
        chk("rst_smp_valid", 32'(smp_valid), 32'd0);
        chk("rst_smp_data", 32'(smp_data), 32'd0);
        chk("rst_wrap_pulse", 32'(wrap_pulse), 32'd0);
        rand_mode = 1'b0;
        enable    = 1'b0;
        rate_sel  = 2'b00;
        smp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_no_read", 32'(flash_read), 32'd0);
        end

        // ---- Normal rate ----
        smp_ready = 1'b1;
        rate_sel  = 2'b00;
        mem[0]    = 32'h4000_C000;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'hFF00);
        fetch_one(n);
        chk("enable_to_read_cycles", 32'(n), 32'd1);
        k = 0;
        while (k < 10 && !flash_readdatavalid) begin tick(); k++; end
        n = 0;
        while (n < 10 && !smp_valid) begin tick(); n++; end
        chk("rdv_to_valid_cycles", 32'(n), 32'd2);
        wait_drain();
        chk("normal_back_to_back", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 32'd1);
        chk("normal_addr_after", 32'(flash_address), 32'd1);
        chk("normal_read_addr", 32'(addr_log[addr_log.size()-1]), 32'd0);

        // ---- Fast rate ----
        rate_sel = 2'b01;
        mem[1]   = 32'h4000_C000;
        exp_q.push_back(16'h0100);
        fetch_one(n);
        wait_drain();
        chk("fast_addr_after", 32'(flash_address), 32'd2);

        // ---- Slow rate, rate_sel changed mid-word ----
        smp_ready = 1'b0;
        rate_sel  = 2'b10;
        mem[2]    = 32'h4000_C000;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'hFF00);
        exp_q.push_back(16'hFF00);
        fetch_one(n);
        wait_valid();
        tick();
        rate_sel = 2'b00;
        tick();
        tick();
        smp_ready = 1'b1;
        tick();
        rate_sel = 2'b01;
        wait_drain();
        chk("slow_addr_after", 32'(flash_address), 32'd3);

        // ---- Backpressure: unpacker holds a word, FIFO fills ----
        rate_sel  = 2'b00;
        smp_ready = 1'b0;
        mem[3]    = 32'h1000_8000;
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'hFE00);
        fetch_one(n);
        wait_valid();
        mem[0] = 32'h7FC0_0040;
        mem[1] = 32'hFFC0_003F;
        mem[2] = 32'hFFFF_0001;
        mem[3] = 32'h8000_7FFF;
        exp_q.push_back(16'h01FF);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFE00);
        exp_q.push_back(16'h01FF);
        rd0    = rd_count;
        enable = 1'b1;
        hi     = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i >= 30 && flash_read) hi++;
        end
        chk("bp_reads", 32'(rd_count - rd0), 32'(TB_DEPTH));
        chk("bp_read_quiet", 32'(hi), 32'd0);
        chk("bp_held_data", 32'(smp_data), 32'h0040);
        enable = 1'b0;
        tick();
        smp_ready = 1'b1;
        wait_drain();
        chk("bp_no_bubble", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-10]), 32'd9);
        chk("bp_addr_after", 32'(flash_address), 32'd0);
        chk("bp_wrap_count", 32'(wrap_cnt), 32'd2);

        // ---- Continuous playback across the wrap ----
        rate_sel = 2'b01;
        mem[0]   = 32'h2000_0000;
        mem[1]   = 32'hE000_0000;
        mem[2]   = 32'h0640_0000;
        mem[3]   = 32'hF9C0_0000;
        exp_q.push_back(16'h0080);
        exp_q.push_back(16'hFF80);
        exp_q.push_back(16'h0019);
        exp_q.push_back(16'hFFE7);
        exp_q.push_back(16'h0080);
        exp_addr = '{23'd0, 23'd1, 23'd2, 23'd3, 23'd0};
        w0  = wrap_cnt;
        lg  = addr_log.size();
        rd0 = rd_count;
        enable = 1'b1;
        k = 0;
        while (k < 200 && rd_count < rd0 + 5) begin tick(); k++; end
        enable = 1'b0;
        chk("wrap_reads", 32'(rd_count - rd0), 32'd5);
        wait_drain();
        for (int i = 0; i < 5; i++) begin
            if (lg + i < addr_log.size())
                chk("wrap_addr_seq", 32'(addr_log[lg+i]), 32'(exp_addr[i]));
            else
                chk("wrap_addr_seq_missing", 32'(i), 32'hFFFF_FFFF);
        end
        chk("wrap_pulse_count", 32'(wrap_cnt - w0), 32'd1);
        chk("wrap_addr_after", 32'(flash_address), 32'd1);

        // ---- Waitrequest held for three cycles ----
        rate_sel = 2'b00;
        ws_cfg   = 3;
        mem[1]   = 32'h4000_C000;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'hFF00);
        rd0 = rd_count;
        fetch_one(n);
        a0 = flash_address;
        hi = 1;
        k  = 0;
        while (k < 20) begin
            tick();
            k++;
            if (!flash_read) break;
            hi++;
            chk("wait_addr_stable", 32'(flash_address), 32'(a0));
        end
        chk("wait_read_cycles", 32'(hi), 32'd4);
        chk("wait_one_read", 32'(rd_count - rd0), 32'd1);
        ws_cfg = 0;
        wait_drain();
        chk("wait_addr_after", 32'(flash_address), 32'd2);

        // ---- Reset during REQ drops flash_read asynchronously ----
        ws_cfg = 10;
        fetch_one(n);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_read", 32'(flash_read), 32'd0);
        chk("async_rst_addr", 32'(flash_address), 32'd0);
        tick();
        ws_cfg = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---- Reset during WAIT_DATA, stale data arrives after release ----
        lat_cfg = 2;
        mem[0]  = 32'h7FFF_7FFF;
        fetch_one(n);
        k = 0;
        while (k < 20 && flash_read) begin tick(); k++; end
        rst_n = 1'b0;
        mem[0] = 32'h4000_C000;
        tick();
        tick();
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (smp_valid) hi++;
        end
        chk("stale_no_sample", 32'(hi), 32'd0);
        chk("stale_addr", 32'(flash_address), 32'd0);
        lat_cfg = 0;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'hFF00);
        lg = addr_log.size();
        fetch_one(n);
        wait_drain();
        chk("restart_read_count", 32'(addr_log.size() - lg), 32'd1);
        if (addr_log.size() > lg)
            chk("restart_addr", 32'(addr_log[lg]), 32'd0);

        tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_sample_fetcher.md
# flash_sample_fetcher

Flash-to-audio sample front end for the audio streamer. It issues single-word Avalon-MM reads to the on-board flash controller and buffers the returned 32-bit words in a small FIFO. It unpacks each word into two signed 16-bit PCM samples, applies the playback-rate policy and output attenuation, and presents one sample at a time on a valid/ready stream. The codec write stage downstream consumes this stream and owns only the codec handshake.

## Interface
Parameters:
- WORDS, 1048576: number of 32-bit words played before the address wraps to 0 (0x200000 samples).
- FIFO_DEPTH, 4: word FIFO entries; power of two, ≥2.
- SHIFT, 6: arithmetic right shift applied to each sample (attenuation).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  high: fetching allowed; low: no new reads are issued, and an outstanding read still completes.
- rate_sel  in  2  00/11 normal, 01 fast (×2), 10 slow (×½).
- flash_read  out  1  Avalon read request.
- flash_address  out  23  word address.
- flash_waitrequest  in  1  Avalon waitrequest.
- flash_readdata  in  32  read data.
- flash_readdatavalid  in  1  read data valid.
- smp_valid  out  1  sample available.
- smp_ready  in  1  downstream accepts sample.
- smp_data  out  16  signed sample.
- wrap_pulse  out  1  one-cycle pulse when flash_address wraps to 0.

## Operation
- The read FSM has three states: IDLE, REQ and WAIT_DATA.
  - IDLE → REQ when enable=1 and fifo_count < FIFO_DEPTH. flash_read rises on the registered transition.
  - REQ: flash_read=1 and flash_address is held. Go to WAIT_DATA on the first cycle with flash_waitrequest=0, then drop flash_read.
  - WAIT_DATA: on flash_readdatavalid, push flash_readdata into the FIFO and advance the address. If the address was WORDS-1, it becomes 0 and wrap_pulse=1 for one cycle. Then go to IDLE.
- There is at most one outstanding read. Room is checked in IDLE, so a push never overflows.
- flash_readdatavalid outside WAIT_DATA is ignored. This also covers stale data after a reset.
- Output unpacker:
  - It pops a word when the unpacker holds no word, or when the last sample of the current word is accepted and the FIFO is non-empty.
  - rate_sel is latched at each pop and applies to that whole word.
  - Sample order per word (hi = [31:16], lo = [15:0]):
    - normal: hi, lo.
    - fast: hi only.
    - slow: hi, hi, lo, lo.
  - smp_data = sample >>> SHIFT, sign-extended to 16 bits.
  - A 2-bit phase counter steps on each accepted sample.
- Stream rules:
  - smp_valid stays high, and smp_data stays stable, until a cycle with smp_ready=1.
  - smp_valid does not depend combinationally on smp_ready.
- FIFO:
  - A simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: flash_read=0, flash_address=0, smp_valid=0, smp_data=0, wrap_pulse=0. FSM in IDLE, FIFO empty, phase=0.
- Reset asserted mid-read drops flash_read asynchronously, and the in-flight word is discarded.
- From enable rising (FIFO empty), flash_read=1 at edge +1.
- From readdatavalid at edge N:
  - the FIFO holds the word at N+1;
  - if the unpacker is empty, smp_valid=1 with the hi sample at N+2.
- Back-to-back samples within one word: one sample per cycle while smp_ready=1.
- Word change with a non-empty FIFO has no bubble: the next word's first sample is valid the cycle after the last sample of the previous word is accepted.
- A rate_sel change takes effect at the next word boundary. It never splits a word.
- If enable is low while in REQ, the read still completes; the FSM then remains in IDLE.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0; release with enable=0 → flash_read stays 0 for 20 cycles.
- Normal rate: flash model returns 0x4000C000 at address 0, smp_ready=1 → smp_data sequence 0x0100, 0xFF00; flash_address advances to 1.
- Fast/slow: same word with rate_sel=01 → single 0x0100. With rate_sel=10 → 0x0100, 0x0100, 0xFF00, 0xFF00. Switching rate_sel mid-word does not alter that word's sequence.
- Backpressure and waitrequest:
  - smp_ready=0 for 50 cycles → exactly FIFO_DEPTH reads complete, then flash_read stays 0, and smp_valid/smp_data stay stable.
  - waitrequest held 3 cycles → flash_read and flash_address stable, and one read is counted.
- Wrap: WORDS=4, continuous playback → address sequence 0, 1, 2, 3, 0, with wrap_pulse high exactly one cycle at the 3→0 advance.
- Reset mid-operation: assert rst_n in WAIT_DATA, then deliver readdatavalid just after release → the word is ignored and the first read after restart is to address 0.
